video_timing_gen: RTL

Raster timing and character-cell address generator for the Micro-80 HDMI video path. It sits directly upstream of the text renderer and the TMDS serializer. It produces the 1280x720@60 pixel/line counters, syncs and blanking. It also produces the 64x32 character-cell window position (column, row, scanline-in-glyph, dot phase) as registered, incrementally counted values, so downstream stages need no divide or modulo by 10. A frame-rate blink flag is provided for the attribute underline/cursor.

---
 rtl/video_pkg.sv | 35 +++
 rtl/video_timing_gen_if.sv | 29 ++
 rtl/vt_axis.sv | 59 +++++
 rtl/video_timing_gen.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared 720p raster constants, text-window geometry and cell-address helper
// for the Micro-80 HDMI video path.
package video_pkg;

  localparam int unsigned CNT_W  = 11;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned COL_W  = 6;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned DOT_W  = 4;
  localparam int unsigned GL_W   = 4;

  localparam int unsigned H_ACTIVE_720 = 1280;
  localparam int unsigned H_FP_720     = 110;
  localparam int unsigned H_SYNC_720   = 40;
  localparam int unsigned H_BP_720     = 220;
  localparam int unsigned V_ACTIVE_720 = 720;
  localparam int unsigned V_FP_720     = 5;
  localparam int unsigned V_SYNC_720   = 5;
  localparam int unsigned V_BP_720     = 20;

  localparam int unsigned WIN_COLS        = 64;
  localparam int unsigned WIN_ROWS        = 32;
  localparam int unsigned CELL_W          = 16;
  localparam int unsigned CELL_H          = 20;
  localparam int unsigned GLYPH_LINES     = 10;
  localparam int unsigned WIN_H_START_DEF = 162;
  localparam int unsigned WIN_V_START_DEF = 64;
  localparam int unsigned BLINK_DIV_DEF   = 32;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing / character-cell bus from the timing generator to the
// text renderer and TMDS serializer.
interface video_timing_gen_if;
  import video_pkg::*;

  logic [CNT_W-1:0]  hcnt;
  logic [CNT_W-1:0]  vcnt;
  logic              hsync;
  logic              vsync;
  logic              visible;
  logic              window;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DOT_W-1:0]  dot;
  logic [GL_W-1:0]   glyph_line;
  logic              line_start;
  logic              frame_start;
  logic              blink;

  modport master (
    output hcnt, vcnt, hsync, vsync, visible, window,
           fetch_addr, dot, glyph_line, line_start, frame_start, blink
  );

  modport slave (
    input  hcnt, vcnt, hsync, vsync, visible, window,
           fetch_addr, dot, glyph_line, line_start, frame_start, blink
  );

endinterface

// File: rtl/vt_axis.sv
// One raster axis: wrapping counter with registered sync, plus next-state
// count/active/wrap so the parent can register flags aligned with the count.
module vt_axis
  import video_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_720,
  parameter int unsigned FP     = H_FP_720,
  parameter int unsigned SYNC   = H_SYNC_720,
  parameter int unsigned BP     = H_BP_720
) (
  input  logic             pixclk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sync,
  output logic [CNT_W-1:0] o_nxt_c,
  output logic             o_act_c,
  output logic             o_wrap_c
);

  localparam int unsigned      TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sync;
  logic [CNT_W-1:0] w_nxt;
  logic             w_wrap;

  always_comb begin
    w_wrap = i_en && (r_cnt == LAST);
    w_nxt  = r_cnt;
    if (w_wrap) begin
      w_nxt = '0;
    end else if (i_en) begin
      w_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Reset parks the count on the last position so the first live cycle is 0.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      r_cnt  <= LAST;
      r_sync <= 1'b0;
    end else begin
      r_cnt  <= w_nxt;
      r_sync <= (w_nxt >= SYNC_BEG) && (w_nxt < SYNC_END);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_sync   = r_sync;
  assign o_nxt_c  = w_nxt;
  assign o_act_c  = w_nxt < ACT_END;
  assign o_wrap_c = w_wrap;

endmodule

// File: rtl/video_timing_gen.sv
// 720p raster timing plus incrementally counted 64x32 text-cell position
// (column one cell ahead, dot, glyph scanline) and a frame-rate blink flag.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_720,
  parameter int unsigned H_FP        = H_FP_720,
  parameter int unsigned H_SYNC      = H_SYNC_720,
  parameter int unsigned H_BP        = H_BP_720,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_720,
  parameter int unsigned V_FP        = V_FP_720,
  parameter int unsigned V_SYNC      = V_SYNC_720,
  parameter int unsigned V_BP        = V_BP_720,
  parameter int unsigned WIN_H_START = WIN_H_START_DEF,
  parameter int unsigned WIN_V_START = WIN_V_START_DEF,
  parameter int unsigned BLINK_DIV   = BLINK_DIV_DEF,
  parameter int unsigned N_COLS      = WIN_COLS,
  parameter int unsigned N_ROWS      = WIN_ROWS
) (
  input  logic               pixclk,
  input  logic               rst,
  video_timing_gen_if.master o_vid
);

  localparam logic [CNT_W-1:0] H_PRE     = CNT_W'(WIN_H_START - CELL_W);
  localparam logic [CNT_W-1:0] H_WIN_BEG = CNT_W'(WIN_H_START);
  localparam logic [CNT_W-1:0] H_WIN_END = CNT_W'(WIN_H_START + N_COLS * CELL_W);
  localparam logic [CNT_W-1:0] V_WIN_BEG = CNT_W'(WIN_V_START);
  localparam logic [CNT_W-1:0] V_WIN_END = CNT_W'(WIN_V_START + N_ROWS * CELL_H);
  localparam logic [DOT_W-1:0] DOT_LAST  = DOT_W'(CELL_W - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(N_COLS - 1);
  localparam logic [GL_W-1:0]  GL_LAST   = GL_W'(GLYPH_LINES - 1);
  localparam int unsigned      FC_W      = $clog2(BLINK_DIV + 1);
  localparam logic [FC_W-1:0]  FC_TOP    = FC_W'(BLINK_DIV);

  logic [CNT_W-1:0] w_hcnt, w_vcnt, w_h_nxt, w_v_nxt;
  logic             w_hsync, w_vsync, w_h_act, w_v_act, w_h_wrap, w_v_wrap;
  logic             w_hspan, w_hwin, w_vwin;
  logic [DOT_W-1:0] w_dot_nxt;
  logic [COL_W-1:0] w_col_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  logic [GL_W-1:0]  w_gl_nxt;
  logic             w_half_nxt;
  logic [FC_W-1:0]  w_fcnt_nxt;
  logic             w_blink_nxt;

  logic             r_visible, r_window, r_line_start, r_frame_start;
  logic [DOT_W-1:0] r_dot;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [GL_W-1:0]  r_gl;
  logic             r_half;
  logic [FC_W-1:0]  r_fcnt;
  logic             r_blink;

  vt_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
    .pixclk   (pixclk),
    .rst      (rst),
    .i_en     (1'b1),
    .o_cnt    (w_hcnt),
    .o_sync   (w_hsync),
    .o_nxt_c  (w_h_nxt),
    .o_act_c  (w_h_act),
    .o_wrap_c (w_h_wrap)
  );

  vt_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
    .pixclk   (pixclk),
    .rst      (rst),
    .i_en     (w_h_wrap),
    .o_cnt    (w_vcnt),
    .o_sync   (w_vsync),
    .o_nxt_c  (w_v_nxt),
    .o_act_c  (w_v_act),
    .o_wrap_c (w_v_wrap)
  );

  // Cell counters advance from the current registers, gated by next-state position.
  always_comb begin
    w_hspan = (w_h_nxt >= H_PRE) && (w_h_nxt < H_WIN_END);
    w_hwin  = (w_h_nxt >= H_WIN_BEG) && (w_h_nxt < H_WIN_END);
    w_vwin  = (w_v_nxt >= V_WIN_BEG) && (w_v_nxt < V_WIN_END);

    w_dot_nxt = '0;
    w_col_nxt = '0;
    if (w_hspan && (w_h_nxt != H_PRE)) begin
      w_dot_nxt = r_dot + DOT_W'(1);
      w_col_nxt = r_col;
      if ((r_dot == DOT_LAST) && (r_col != COL_LAST)) begin
        w_col_nxt = r_col + COL_W'(1);
      end
    end

    w_row_nxt  = r_row;
    w_gl_nxt   = r_gl;
    w_half_nxt = r_half;
    if (w_v_wrap || !w_vwin) begin
      w_row_nxt  = '0;
      w_gl_nxt   = '0;
      w_half_nxt = 1'b0;
    end else if (w_h_wrap) begin
      if (w_v_nxt == V_WIN_BEG) begin
        w_row_nxt  = '0;
        w_gl_nxt   = '0;
        w_half_nxt = 1'b0;
      end else if (!r_half) begin
        w_half_nxt = 1'b1;
      end else begin
        w_half_nxt = 1'b0;
        if (r_gl == GL_LAST) begin
          w_gl_nxt  = '0;
          w_row_nxt = r_row + ROW_W'(1);
        end else begin
          w_gl_nxt = r_gl + GL_W'(1);
        end
      end
    end

    // Counter runs 1..BLINK_DIV so the first frame after reset is not a toggle.
    w_fcnt_nxt  = r_fcnt;
    w_blink_nxt = r_blink;
    if (w_v_wrap) begin
      if (r_fcnt == FC_TOP) begin
        w_fcnt_nxt  = FC_W'(1);
        w_blink_nxt = ~r_blink;
      end else begin
        w_fcnt_nxt = r_fcnt + FC_W'(1);
      end
    end
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      r_visible     <= 1'b0;
      r_window      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_dot         <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_gl          <= '0;
      r_half        <= 1'b0;
      r_fcnt        <= '0;
      r_blink       <= 1'b0;
    end else begin
      r_visible     <= w_h_act && w_v_act;
      r_window      <= w_hwin && w_vwin;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
      r_dot         <= w_dot_nxt;
      r_col         <= w_col_nxt;
      r_row         <= w_row_nxt;
      r_gl          <= w_gl_nxt;
      r_half        <= w_half_nxt;
      r_fcnt        <= w_fcnt_nxt;
      r_blink       <= w_blink_nxt;
    end
  end

  assign o_vid.hcnt        = w_hcnt;
  assign o_vid.vcnt        = w_vcnt;
  assign o_vid.hsync       = w_hsync;
  assign o_vid.vsync       = w_vsync;
  assign o_vid.visible     = r_visible;
  assign o_vid.window      = r_window;
  assign o_vid.fetch_addr  = cell_addr(r_row, r_col);
  assign o_vid.dot         = r_dot;
  assign o_vid.glyph_line  = r_gl;
  assign o_vid.line_start  = r_line_start;
  assign o_vid.frame_start = r_frame_start;
  assign o_vid.blink       = r_blink;

endmodule
